// File: rtl/sobel_ctrl.sv
// 3x3 Sobel magnitude over a raster pixel stream, with two line buffers and a shift window.
// Result registered 1 cycle after acceptance; a stalled result holds its data and blocks input.
module sobel_ctrl #(
  parameter int IMG_W = 128,
  parameter int IMG_H = 128
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_px,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [16:0] out_mag,
  output logic [7:0]  out_px,
  output logic [9:0]  out_row,
  output logic [9:0]  out_col,
  output logic        busy,
  output logic        done
);

  localparam int AW = $clog2(IMG_W);
  localparam logic [9:0] COL_LAST = 10'(IMG_W - 1);
  localparam logic [9:0] ROW_LAST = 10'(IMG_H - 1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
  state_t state, state_nxt;

  logic [9:0] row, col;
  logic [7:0] lb1 [IMG_W];
  logic [7:0] lb2 [IMG_W];
  logic [7:0] t0, t1, m0, m1, b0, b1;
  logic [7:0] top, mid;
  logic [AW-1:0] col_idx;
  logic accept, col_wrap, last_px, win_ok;
  logic [9:0] gx_p, gx_n, gy_p, gy_n;
  logic signed [11:0] gx, gy;
  logic [10:0] ax, ay, mag;

  assign col_idx  = col[AW-1:0];
  assign top      = lb2[col_idx];
  assign mid      = lb1[col_idx];
  assign accept   = in_valid && in_ready;
  assign col_wrap = (col == COL_LAST);
  assign last_px  = col_wrap && (row == ROW_LAST);
  // Rows 0..1 and cols 0..1 only prime the window; their buffer/window slots are
  // always rewritten in the current frame before any result reads them.
  assign win_ok   = (row >= 10'd2) && (col >= 10'd2);

  // Window: t* = row r-2, m* = row r-1, b* = row r; the current column comes straight
  // from the line buffers and the incoming pixel.
  always_comb begin
    gx_p = {2'b00, top} + {1'b0, mid, 1'b0} + {2'b00, in_px};
    gx_n = {2'b00, t0}  + {1'b0, m0, 1'b0}  + {2'b00, b0};
    gy_p = {2'b00, t0}  + {1'b0, t1, 1'b0}  + {2'b00, top};
    gy_n = {2'b00, b0}  + {1'b0, b1, 1'b0}  + {2'b00, in_px};
    gx   = $signed({2'b00, gx_p}) - $signed({2'b00, gx_n});
    gy   = $signed({2'b00, gy_p}) - $signed({2'b00, gy_n});
    ax   = gx[11] ? 11'(-gx) : 11'(gx);
    ay   = gy[11] ? 11'(-gy) : 11'(gy);
    mag  = ax + ay;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (accept && last_px) state_nxt = FLUSH;
      FLUSH:   if (!out_valid || out_ready) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == RUN) && (!out_valid || out_ready);
    busy     = (state == RUN) || (state == FLUSH);
    done     = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      row       <= '0;
      col       <= '0;
      out_valid <= 1'b0;
      out_mag   <= '0;
      out_px    <= '0;
      out_row   <= '0;
      out_col   <= '0;
    end else begin
      if (state == IDLE && start) begin
        row <= '0;
        col <= '0;
      end
      if (accept) begin
        col <= col_wrap ? 10'd0 : col + 10'd1;
        row <= col_wrap ? row + 10'd1 : row;
      end
      if (accept && win_ok) begin
        out_valid <= 1'b1;
        out_mag   <= {6'd0, mag};
        out_px    <= (mag > 11'd255) ? 8'd255 : mag[7:0];
        out_row   <= row - 10'd1;
        out_col   <= col - 10'd1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      lb2[col_idx] <= mid;
      lb1[col_idx] <= in_px;
      t0 <= t1;  t1 <= top;
      m0 <= m1;  m1 <= mid;
      b0 <= b1;  b1 <= in_px;
    end
  end

endmodule

// File: doc/sobel_ctrl.md
SOBEL_CTRL -- requirements
Module: sobel_ctrl

Interface
REQ-001 The block SHALL have parameter IMG_W, default 128, meaning image width in pixels; legal values are 3 to 1024.
REQ-002 The block SHALL have parameter IMG_H, default 128, meaning image height in pixels; legal values are 3 to 1024.
REQ-003 clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  single-cycle frame start request.
REQ-006 in_valid  input  1  in_px holds a valid pixel.
REQ-007 in_ready  output  1  block accepts a pixel this cycle.
REQ-008 in_px  input  8  unsigned pixel, raster order (row 0 col 0 first).
REQ-009 out_valid  output  1  out_mag, out_px, out_row and out_col hold a valid result.
REQ-010 out_ready  input  1  downstream accepts the result this cycle.
REQ-011 out_mag  output  17  unsigned |Gx|+|Gy| for the window.
REQ-012 out_px  output  8  out_mag clamped to 255.
REQ-013 out_row  output  10  row of the window centre.
REQ-014 out_col  output  10  column of the window centre.
REQ-015 busy  output  1  high in RUN and FLUSH.
REQ-016 done  output  1  one-cycle pulse at frame end.

Function
REQ-017 FSM states SHALL be IDLE, RUN, FLUSH and DONE.
- IDLE->RUN on start.
- RUN->FLUSH on acceptance of pixel (IMG_H-1, IMG_W-1).
- FLUSH->DONE when out_valid is low or an output handshake occurs.
- DONE->IDLE unconditionally after 1 cycle.
REQ-018 start SHALL be ignored outside IDLE.
REQ-019 Pixel acceptance SHALL occur when in_valid && in_ready.
- in_ready = (state==RUN) && (!out_valid || out_ready).
REQ-020 Each accepted pixel SHALL advance the column counter; at IMG_W-1 the column wraps to 0 and the row increments.
REQ-021 Two line buffers of IMG_W x 8 bits plus a 3x3 shift window SHALL hold rows r-2, r-1 and r while row r is being accepted.
REQ-022 Window mapping for an accepted pixel at (r,c) with r>=2 and c>=2:
- px_1..px_3 = row r-2, cols c-2..c
- px_4..px_6 = row r-1, cols c-2..c
- px_7..px_9 = row r, cols c-2..c (px_9 = current pixel)
REQ-023 Gx kernel SHALL be [-1 0 1; -2 0 2; -1 0 1]; Gy kernel SHALL be [1 2 1; 0 0 0; -1 -2 -1]; both SHALL be evaluated with signed arithmetic on zero-extended pixels with no overflow.
REQ-024 out_mag SHALL equal |Gx|+|Gy| (maximum 2040); out_px SHALL equal min(out_mag, 255).
REQ-025 A result SHALL be registered in the cycle after acceptance of any pixel with r>=2 and c>=2, with out_row=r-1 and out_col=c-1; no result SHALL be produced for other pixels.
REQ-026 Latency from pixel acceptance to out_valid SHALL be exactly 1 cycle.
REQ-027 Exactly (IMG_W-2)*(IMG_H-2) results SHALL be produced per frame, in raster order.
REQ-028 While out_valid && !out_ready, all output data SHALL be held stable and in_ready SHALL be low.
REQ-029 out_valid SHALL clear on handshake unless a new result is loaded in the same cycle.
REQ-030 Line-buffer and window contents from a previous frame SHALL NOT affect any result of a new frame.
REQ-031 done SHALL be high only in the DONE state; busy SHALL be high in RUN and FLUSH.

Reset
REQ-032 On reset the block SHALL enter IDLE with counters at 0 and out_valid, in_ready, busy and done at 0.
REQ-033 On reset out_mag, out_px, out_row and out_col SHALL be 0.
REQ-034 Reset asserted mid-frame SHALL abort the frame, drop any pending result, and require a new start.
REQ-035 Line-buffer RAM SHALL NOT require reset.

Verification (IMG_W=IMG_H=4)
REQ-036 Flat frame: start, then 16 pixels of 100 -> 4 results, all out_mag=0, at (1,1),(1,2),(2,1),(2,2); done pulses once.
REQ-037 Vertical step: cols 0-1 = 0, cols 2-3 = 255 -> all 4 results have out_mag=1020 and out_px=255.
REQ-038 Horizontal edge: row 0 = 10, rest = 0 -> row-1 results out_mag=40, out_px=40; row-2 results out_mag=0.
REQ-039 Backpressure: out_ready low for 5 cycles on the first result -> out_valid stays 1, data stable, in_ready=0; all 4 results are delivered in order after release.
REQ-040 Reset after 9 pixels, then a new start with the flat-100 frame -> no stale result, exactly 4 zero results, single done pulse.
REQ-041 start pulsed during RUN -> ignored; frame completes normally with 4 results.
